// File: rtl/hazard_unit_mc.sv
// Multi-cycle hazard unit beside ID: load-use bubbles, data-memory wait freeze with
// watchdog, taken-branch flush, and a saturating stall-cycle counter.
module hazard_unit_mc #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      instr_i,
    input  logic             uses_rt_i,
    input  logic [4:0]       ID_EX_RegRt_i,
    input  logic             MemRead_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             branch_taken_i,
    output logic             PC_o,
    output logic             IF_ID_o,
    output logic             mux8_o,
    output logic             pipe_stall_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             timeout_o
);

    localparam int unsigned LCNT_W = $clog2(LOAD_LAT + 1);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, LSTALL} state_t;

    state_t              state;
    logic [LCNT_W-1:0]   lcnt;
    logic [WCNT_W-1:0]   wcnt;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic                mem_busy;
    logic                hit;
    logic                unused_instr;

    assign rs           = instr_i[25:21];
    assign rt           = instr_i[20:16];
    assign unused_instr = ^{instr_i[31:26], instr_i[15:0]};
    assign mem_busy     = mem_req_i & ~mem_ack_i;
    // $0 can never carry a hazard since writes to it are discarded
    assign hit = MemRead_i & (ID_EX_RegRt_i != 5'd0) &
                 ((ID_EX_RegRt_i == rs) | (uses_rt_i & (ID_EX_RegRt_i == rt)));

    // Output decode; memory wait outranks load-use, which outranks branch flush
    always_comb begin
        PC_o         = 1'b0;
        IF_ID_o      = 1'b0;
        mux8_o       = 1'b0;
        pipe_stall_o = 1'b0;
        flush_o      = 1'b0;
        if (!rst_i) begin
            PC_o = 1'b0;
        end else if (mem_busy) begin
            PC_o         = 1'b1;
            IF_ID_o      = 1'b1;
            pipe_stall_o = 1'b1;
        end else if ((state == LSTALL) || hit) begin
            PC_o    = 1'b1;
            IF_ID_o = 1'b1;
            mux8_o  = 1'b1;
        end else begin
            flush_o = branch_taken_i;
        end
    end

    // Bubble sequencing, watchdog and stall counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            lcnt        <= '0;
            wcnt        <= '0;
            stall_cnt_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            if (!mem_busy) begin
                case (state)
                    IDLE: begin
                        if (hit && (LOAD_LAT > 1)) begin
                            state <= LSTALL;
                            lcnt  <= LCNT_W'(LOAD_LAT - 1);
                        end
                    end
                    LSTALL: begin
                        lcnt <= lcnt - LCNT_W'(1);
                        if (lcnt == LCNT_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (mem_busy) begin
                if (wcnt != WCNT_W'(TIMEOUT)) begin
                    wcnt <= wcnt + WCNT_W'(1);
                end
                if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
                    timeout_o <= 1'b1;
                end
            end else begin
                wcnt <= '0;
            end

            if (PC_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule
